// File: rtl/rx_drain_ctrl.sv
// Receive drain controller: acknowledges bytes from a UART-style receiver into a
// small FIFO and keeps saturating counts of framing and overrun errors.
module rx_drain_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcv_data_ready,
  input  logic [7:0] rcv_rx_data,
  input  logic       rcv_framing_error,
  input  logic       rcv_overrun_error,
  output logic       rcv_data_read,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       head_valid,
  output logic [3:0] fill,
  output logic [7:0] ferr_cnt,
  output logic [7:0] ovr_cnt,
  input  logic       clr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [3:0]    FULL_FILL = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [3:0]      fill_r;
  logic            capture_s;
  logic            pop_s;
  logic            ferr_prev_r;
  logic            ovr_prev_r;
  logic [7:0]      ferr_cnt_r;
  logic [7:0]      ovr_cnt_r;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    ptr_inc = (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  // Full check uses the pre-edge fill so a same-cycle pop never unblocks a capture.
  assign capture_s = (state_r == IDLE) && rcv_data_ready && (fill_r < FULL_FILL);
  assign pop_s     = pop && (fill_r != 4'd0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; WAIT_CLR holds until ready drops so one byte is taken once.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (capture_s) next_state_s = ACK;
        else           next_state_s = IDLE;
      end
      ACK:  next_state_s = WAIT_CLR;
      WAIT_CLR: begin
        if (!rcv_data_ready) next_state_s = IDLE;
        else                 next_state_s = WAIT_CLR;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FIFO storage write; contents need no reset because fill gates visibility.
  always_ff @(posedge clk) begin
    if (capture_s && !rst) begin
      mem_r[wr_ptr_r] <= rcv_rx_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= 4'd0;
    end else begin
      if (capture_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)     rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({capture_s, pop_s})
        2'b10:   fill_r <= fill_r + 4'd1;
        2'b01:   fill_r <= fill_r - 4'd1;
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Error edge detection and saturating counters; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      ferr_prev_r <= 1'b0;
      ovr_prev_r  <= 1'b0;
      ferr_cnt_r  <= 8'd0;
      ovr_cnt_r   <= 8'd0;
    end else begin
      ferr_prev_r <= rcv_framing_error;
      ovr_prev_r  <= rcv_overrun_error;
      if (clr_cnt) begin
        ferr_cnt_r <= 8'd0;
        ovr_cnt_r  <= 8'd0;
      end else begin
        if (rcv_framing_error && !ferr_prev_r && (ferr_cnt_r != 8'hFF))
          ferr_cnt_r <= ferr_cnt_r + 8'd1;
        if (rcv_overrun_error && !ovr_prev_r && (ovr_cnt_r != 8'hFF))
          ovr_cnt_r <= ovr_cnt_r + 8'd1;
      end
    end
  end

  assign rcv_data_read = (state_r == ACK);
  assign head_data     = mem_r[rd_ptr_r];
  assign head_valid    = (fill_r != 4'd0);
  assign fill          = fill_r;
  assign ferr_cnt      = ferr_cnt_r;
  assign ovr_cnt       = ovr_cnt_r;

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Bench for rx_drain_ctrl: reset/handshake vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_rx_drain_ctrl;

  localparam int DEPTH = 4;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rcv_data_ready = 1'b0;
  logic [7:0] rcv_rx_data = 8'h00;
  logic       rcv_framing_error = 1'b0;
  logic       rcv_overrun_error = 1'b0;
  logic       rcv_data_read;
  logic       pop = 1'b0;
  logic [7:0] head_data;
  logic       head_valid;
  logic [3:0] fill;
  logic [7:0] ferr_cnt;
  logic [7:0] ovr_cnt;
  logic       clr_cnt = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  rx_drain_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(tb_clk), .rst(rst),
    .rcv_data_ready(rcv_data_ready), .rcv_rx_data(rcv_rx_data),
    .rcv_framing_error(rcv_framing_error), .rcv_overrun_error(rcv_overrun_error),
    .rcv_data_read(rcv_data_read), .pop(pop),
    .head_data(head_data), .head_valid(head_valid), .fill(fill),
    .ferr_cnt(ferr_cnt), .ovr_cnt(ovr_cnt), .clr_cnt(clr_cnt)
  );

  always #5 tb_clk = ~tb_clk;

  // Reference model: byte queue plus a "handshake busy" flag that is released
  // by the first low ready seen at least two edges after a capture.
  logic [7:0] m_q[$];
  bit         m_busy = 1'b0;
  int         m_settle = 0;
  bit         m_read = 1'b0;
  int         m_ferr = 0;
  int         m_ovr = 0;
  bit         m_fprev = 1'b0;
  bit         m_oprev = 1'b0;

  task automatic model_edge();
    bit cap;
    bit do_pop;
    if (rst) begin
      m_q.delete();
      m_busy = 1'b0; m_settle = 0; m_read = 1'b0;
      m_ferr = 0; m_ovr = 0; m_fprev = 1'b0; m_oprev = 1'b0;
    end else begin
      cap    = !m_busy && rcv_data_ready && (m_q.size() < DEPTH);
      do_pop = pop && (m_q.size() > 0);
      m_read = cap;
      if (cap) begin
        m_busy = 1'b1; m_settle = 1;
      end else if (m_busy) begin
        if (m_settle > 0) m_settle--;
        else if (!rcv_data_ready) m_busy = 1'b0;
      end
      if (do_pop) void'(m_q.pop_front());
      if (cap) m_q.push_back(rcv_rx_data);
      if (clr_cnt) begin
        m_ferr = 0; m_ovr = 0;
      end else begin
        if (rcv_framing_error && !m_fprev && m_ferr < 255) m_ferr++;
        if (rcv_overrun_error && !m_oprev && m_ovr < 255) m_ovr++;
      end
      m_fprev = rcv_framing_error;
      m_oprev = rcv_overrun_error;
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("rnd_fill", 32'(fill), 32'(m_q.size()));
    chk("rnd_valid", 32'(head_valid), 32'(m_q.size() > 0));
    chk("rnd_read", 32'(rcv_data_read), 32'(m_read));
    chk("rnd_ferr", 32'(ferr_cnt), 32'(m_ferr));
    chk("rnd_ovr", 32'(ovr_cnt), 32'(m_ovr));
    if (m_q.size() > 0) chk("rnd_head", 32'(head_data), 32'(m_q[0]));
  endtask

  task automatic clear_inputs();
    rcv_data_ready = 1'b0; rcv_rx_data = 8'h00; pop = 1'b0;
    rcv_framing_error = 1'b0; rcv_overrun_error = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rcv_data_ready = 1'b1; rcv_rx_data = b;
    tick();
    chk("send_pulse", 32'(rcv_data_read), 32'd1);
    tick();
    chk("send_pulse_end", 32'(rcv_data_read), 32'd0);
    rcv_data_ready = 1'b0;
    tick();
  endtask

  typedef struct {
    logic       rst, rdy;
    logic [7:0] data;
    logic       pop, fe, oe, clr;
    logic       exp_read;
    logic [3:0] exp_fill;
    logic       exp_valid;
    logic [7:0] exp_head, exp_ferr, exp_ovr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0] order[4];
    //                 rst   rdy   data   pop   fe    oe    clr   read  fill  valid head   ferr   ovr
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'd0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'd0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 8'hD5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 8'hD5, 8'd0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 8'hD5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 8'hD5, 8'd0, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 8'hD5, 8'd0, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'd0, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'd1, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'd1, 8'd0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'd1, 8'd1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 8'd0, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'd1, 8'd0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'd1, 8'd0};

    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; rcv_data_ready = vecs[i].rdy; rcv_rx_data = vecs[i].data;
      pop = vecs[i].pop; rcv_framing_error = vecs[i].fe;
      rcv_overrun_error = vecs[i].oe; clr_cnt = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_read", i), 32'(rcv_data_read), 32'(vecs[i].exp_read));
      chk($sformatf("vec%0d_fill", i), 32'(fill), 32'(vecs[i].exp_fill));
      chk($sformatf("vec%0d_valid", i), 32'(head_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_ferr", i), 32'(ferr_cnt), 32'(vecs[i].exp_ferr));
      chk($sformatf("vec%0d_ovr", i), 32'(ovr_cnt), 32'(vecs[i].exp_ovr));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_head", i), 32'(head_data), 32'(vecs[i].exp_head));
    end

    // Fill to full, back-pressure, and pop-then-capture ordering.
    do_reset();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("full_fill", 32'(fill), 32'd4);
    rcv_data_ready = 1'b1; rcv_rx_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_no_pulse", 32'(rcv_data_read), 32'd0);
      chk("full_hold", 32'(fill), 32'd4);
    end
    pop = 1'b1;
    tick();
    chk("full_pop_no_unblock", 32'(rcv_data_read), 32'd0);
    chk("full_pop_fill", 32'(fill), 32'd3);
    pop = 1'b0;
    tick();
    chk("full_late_pulse", 32'(rcv_data_read), 32'd1);
    chk("full_late_fill", 32'(fill), 32'd4);
    tick();
    rcv_data_ready = 1'b0;
    tick();
    order[0] = 8'h22; order[1] = 8'h33; order[2] = 8'h44; order[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      chk("full_order", 32'(head_data), 32'(order[i]));
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    chk("full_drained", 32'(fill), 32'd0);
    chk("full_drained_valid", 32'(head_valid), 32'd0);

    // Capture and pop on the same edge.
    do_reset();
    send_byte(8'hA1); send_byte(8'hA2);
    rcv_data_ready = 1'b1; rcv_rx_data = 8'hA3; pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("sim_fill", 32'(fill), 32'd2);
    chk("sim_head", 32'(head_data), 32'hA2);
    chk("sim_pulse", 32'(rcv_data_read), 32'd1);
    tick();
    rcv_data_ready = 1'b0;
    tick();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("sim_head2", 32'(head_data), 32'hA3);
    chk("sim_fill2", 32'(fill), 32'd1);

    // Counter saturation and clear priority.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rcv_framing_error = 1'b1; tick();
      rcv_framing_error = 1'b0; tick();
    end
    chk("ferr_sat", 32'(ferr_cnt), 32'd255);
    rcv_overrun_error = 1'b1; clr_cnt = 1'b1;
    tick();
    chk("clr_prio_ovr", 32'(ovr_cnt), 32'd0);
    chk("clr_prio_ferr", 32'(ferr_cnt), 32'd0);
    clr_cnt = 1'b0;
    tick();
    chk("ovr_level_no_inc", 32'(ovr_cnt), 32'd0);
    rcv_overrun_error = 1'b0;

    // Reset during WAIT_CLR with fill=3, ready still high afterwards.
    do_reset();
    send_byte(8'hB1); send_byte(8'hB2);
    rcv_data_ready = 1'b1; rcv_rx_data = 8'h77;
    tick();
    chk("mid_cap_fill", 32'(fill), 32'd3);
    tick();
    chk("mid_wait_fill", 32'(fill), 32'd3);
    rst = 1'b1;
    tick();
    chk("mid_rst_fill", 32'(fill), 32'd0);
    chk("mid_rst_valid", 32'(head_valid), 32'd0);
    chk("mid_rst_read", 32'(rcv_data_read), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_recap_pulse", 32'(rcv_data_read), 32'd1);
    chk("mid_recap_fill", 32'(fill), 32'd1);
    chk("mid_recap_head", 32'(head_data), 32'h77);
    tick();
    rcv_data_ready = 1'b0;
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) rcv_data_ready = ~rcv_data_ready;
      rcv_rx_data = 8'($urandom);
      pop = ($urandom_range(0, 9) < 4);
      rcv_framing_error = ($urandom_range(0, 2) == 0);
      rcv_overrun_error = ($urandom_range(0, 2) == 0);
      clr_cnt = ($urandom_range(0, 29) == 0);
      tick();
      chk_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
